pic_page_scheduler: RTL and testbench



---
 rtl/pic_page_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_pic_page_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_page_scheduler.sv
// Purpose: picks the picture page the display reader shows; debounces page requests
//          over whole frames, prefetches the new page, switches only at a frame start.
// Latency: non-boss STABLE_FRAMES frame starts + handshake + 1 frame start; boss skips the debounce.
// Backpressure: load_req holds with a stable load_base until load_ack; PREFETCH/WAIT_DONE bounded by TIMEOUT_CYC.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   picnum, isboss        requested page (0..9 valid) and boss override
//   vsync_start           one-cycle frame-start pulse
//   load_req/load_base    prefetch request and page base address to the reader
//   load_ack/load_done    reader accepted the base / first-line prefetch complete
//   disp_page/disp_base   currently displayed page and its base address
//   commit                one-cycle pulse when disp_page/disp_base change
//   busy, err             switch in progress / one-cycle handshake timeout pulse
module pic_page_scheduler #(
    parameter int STABLE_FRAMES = 3,
    parameter int PAGE_WORDS    = 307200,
    parameter int ADDR_W        = 23,
    parameter int BOSS_PAGE     = 10,
    parameter int TIMEOUT_CYC   = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        picnum,
    input  logic              isboss,
    input  logic              vsync_start,
    output logic              load_req,
    output logic [ADDR_W-1:0] load_base,
    input  logic              load_ack,
    input  logic              load_done,
    output logic [4:0]        disp_page,
    output logic [ADDR_W-1:0] disp_base,
    output logic              commit,
    output logic              busy,
    output logic              err
);

    localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0]        BOSS     = 5'(BOSS_PAGE);
    localparam logic [3:0]        STABLE   = 4'(STABLE_FRAMES);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PREFETCH  = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_ARMED     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_cand;
    logic [3:0]       r_cnt;
    logic [4:0]       r_pend;
    logic [TMO_W-1:0] r_tmo;

    logic [4:0]       w_target;
    logic             w_qualified;
    logic             w_tmo_hit;
    logic             w_preempt;
    logic             w_load_req_nxt;
    logic             w_busy_nxt;
    logic             w_err_nxt;
    logic             w_commit_nxt;

    // Full-width product, then truncated to the SDRAM address width.
    function automatic logic [ADDR_W-1:0] f_page_base(input logic [4:0] page);
        return ADDR_W'(64'(page) * 64'(PAGE_WORDS));
    endfunction

    // An out-of-range picnum leaves the target where it was; cand always tracks
    // the previous target, so it stands in for it.
    always_comb begin
        w_target = r_cand;
        if (isboss) begin
            w_target = BOSS;
        end else if (picnum <= 5'd9) begin
            w_target = picnum;
        end
    end

    assign w_qualified = (r_cand == BOSS) || (r_cnt == STABLE);
    assign w_tmo_hit   = (r_tmo == TMO_LAST);
    // Boss request while a non-boss page waits for its frame: drop it, restart.
    assign w_preempt   = (r_cand == BOSS) && (r_pend != BOSS);

    // Frame-count qualifier; a target change restarts the count even if a
    // frame start arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= 5'd0;
            r_cnt  <= 4'd0;
        end else if (w_target != r_cand) begin
            r_cand <= w_target;
            r_cnt  <= 4'd0;
        end else if (vsync_start && (r_cnt != STABLE)) begin
            r_cnt  <= r_cnt + 4'd1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. The reader is mid-transaction in PREFETCH/WAIT_DONE, so
    // only the timeout leaves those states early.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_qualified && (r_cand != disp_page)) begin
                    w_state_nxt = S_PREFETCH;
                end
            end
            S_PREFETCH: begin
                if (load_ack) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (load_done) begin
                    w_state_nxt = S_ARMED;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ARMED: begin
                if (w_preempt || vsync_start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs, computed one cycle ahead so every port is a flop.
    always_comb begin
        w_load_req_nxt = (w_state_nxt == S_PREFETCH);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        w_err_nxt      = 1'b0;
        w_commit_nxt   = 1'b0;
        case (r_state)
            S_PREFETCH:  w_err_nxt    = w_tmo_hit && !load_ack;
            S_WAIT_DONE: w_err_nxt    = w_tmo_hit && !load_done;
            S_ARMED:     w_commit_nxt = vsync_start && !w_preempt;
            default:     ;
        endcase
    end

    // Timeout counter restarts on every state change (covers both entries).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmo <= '0;
        end else if ((r_state == S_PREFETCH) || (r_state == S_WAIT_DONE)) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= 5'd0;
            load_req  <= 1'b0;
            load_base <= '0;
            disp_page <= 5'd0;
            disp_base <= '0;
            commit    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            load_req <= w_load_req_nxt;
            busy     <= w_busy_nxt;
            err      <= w_err_nxt;
            commit   <= w_commit_nxt;
            // load_base is only written on the IDLE decision, so it is stable
            // for the whole time load_req is high.
            if ((r_state == S_IDLE) && (w_state_nxt == S_PREFETCH)) begin
                r_pend    <= r_cand;
                load_base <= f_page_base(r_cand);
            end
            if (w_commit_nxt) begin
                disp_page <= r_pend;
                disp_base <= f_page_base(r_pend);
            end
        end
    end

endmodule

// File: tb/tb_pic_page_scheduler.sv
module tb_pic_page_scheduler;

    localparam int ADDR_W = 23;
    localparam int PW     = 307200;
    localparam int GAP    = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        picnum;
    logic              isboss;
    logic              vsync_start;
    logic              load_req;
    logic [ADDR_W-1:0] load_base;
    logic              load_ack;
    logic              load_done;
    logic [4:0]        disp_page;
    logic [ADDR_W-1:0] disp_base;
    logic              commit;
    logic              busy;
    logic              err;

    pic_page_scheduler #(
        .STABLE_FRAMES(3),
        .PAGE_WORDS   (PW),
        .ADDR_W       (ADDR_W),
        .BOSS_PAGE    (10),
        .TIMEOUT_CYC  (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .picnum     (picnum),
        .isboss     (isboss),
        .vsync_start(vsync_start),
        .load_req   (load_req),
        .load_base  (load_base),
        .load_ack   (load_ack),
        .load_done  (load_done),
        .disp_page  (disp_page),
        .disp_base  (disp_base),
        .commit     (commit),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard: pages expected on the next load_req rise / next commit.
    int exp_req_q[$];
    int exp_com_q[$];

    // Reader model knobs
    int ack_dly  = 2;
    int done_dly = 5;
    bit done_en  = 1'b1;
    bit err_ok   = 1'b0;
    int rd_phase = 0;
    int rd_cnt   = 0;

    // Monitor state
    bit                prev_req  = 1'b0;
    logic [ADDR_W-1:0] prev_base = '0;
    int                run_len   = 0;
    int                last_len  = 0;
    int                mon_pg    = 0;

    typedef struct {
        int pic;
        bit boss;
        int nfr;
        int req_pg;
        int com_pg;
        int exp_pg;
    } step_t;

    step_t steps[8];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            repeat (2) tick();
            vsync_start = 1'b1;
            tick();
            vsync_start = 1'b0;
            repeat (GAP) tick();
        end
    endtask

    // Display reader: ack ack_dly cycles after seeing load_req, done
    // done_dly cycles after the ack (never if done_en is low).
    initial begin
        load_ack  = 1'b0;
        load_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            load_ack  = 1'b0;
            load_done = 1'b0;
            if (!rst_n) begin
                rd_phase = 0;
            end else begin
                if (rd_phase == 0) begin
                    if (load_req) begin
                        rd_phase = 1;
                        rd_cnt   = 0;
                    end
                end else begin
                    rd_cnt++;
                end
                if (rd_phase == 1 && rd_cnt == ack_dly) begin
                    load_ack = 1'b1;
                    rd_phase = 2;
                    rd_cnt   = 0;
                end else if (rd_phase == 2 && done_en && rd_cnt == done_dly) begin
                    load_done = 1'b1;
                    rd_phase  = 0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on load_req rises and commits.
    always @(negedge clk) begin
        if (load_req && !prev_req) begin
            if (exp_req_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_load_req: load_base=%0d expected no request", load_base);
            end else begin
                mon_pg = exp_req_q.pop_front();
                chk("load_base", load_base, longint'(mon_pg) * PW);
            end
        end
        if (load_req && prev_req) begin
            chk("load_base_stable", load_base, prev_base);
        end
        if (load_req) begin
            run_len++;
        end else if (run_len > 0) begin
            last_len = run_len;
            run_len  = 0;
        end
        prev_req  = load_req;
        prev_base = load_base;
        if (commit) begin
            if (exp_com_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_commit: disp_page=%0d expected no commit", disp_page);
            end else begin
                mon_pg = exp_com_q.pop_front();
                chk("commit_disp_page", disp_page, mon_pg);
                chk("commit_disp_base", disp_base, longint'(mon_pg) * PW);
            end
        end
        if (err && !err_ok) begin
            total++;
            bad++;
            $display("FAIL unexpected_err: err=1 expected 0");
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int w;
        int n;
        //            pic boss nfr req  com  disp
        steps[0] = '{4,  1'b0, 2, -1, -1,  0};   // glitch: 4 for two frames
        steps[1] = '{0,  1'b0, 4, -1, -1,  0};   // back to 0: nothing happens
        steps[2] = '{3,  1'b0, 2, -1, -1,  0};   // debounce: two frames, no req
        steps[3] = '{3,  1'b0, 1,  3, -1,  0};   // third frame start -> prefetch
        steps[4] = '{3,  1'b0, 1, -1,  3,  3};   // next frame start -> commit
        steps[5] = '{15, 1'b0, 4, -1, -1,  3};   // invalid picnum ignored
        steps[6] = '{3,  1'b1, 2, 10, 10, 10};   // boss bypasses debounce
        steps[7] = '{3,  1'b0, 4,  3,  3,  3};   // leave boss: full debounce

        picnum      = 5'd0;
        isboss      = 1'b0;
        vsync_start = 1'b0;
        rst_n       = 1'b0;
        repeat (3) tick();
        chk("rst_load_req", load_req, 0);
        chk("rst_load_base", load_base, 0);
        chk("rst_disp_page", disp_page, 0);
        chk("rst_disp_base", disp_base, 0);
        chk("rst_commit", commit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 8; i++) begin
            picnum = 5'(steps[i].pic);
            isboss = steps[i].boss;
            if (steps[i].req_pg >= 0) exp_req_q.push_back(steps[i].req_pg);
            if (steps[i].com_pg >= 0) exp_com_q.push_back(steps[i].com_pg);
            frame(steps[i].nfr);
            chk($sformatf("step%0d_disp_page", i), disp_page, steps[i].exp_pg);
            chk($sformatf("step%0d_disp_base", i), disp_base, longint'(steps[i].exp_pg) * PW);
            chk($sformatf("step%0d_req_pending", i), exp_req_q.size(), 0);
            chk($sformatf("step%0d_commit_pending", i), exp_com_q.size(), 0);
        end

        // Boss preempts a page that is already ARMED.
        picnum = 5'd2;
        exp_req_q.push_back(2);
        frame(3);
        chk("preempt_armed_busy", busy, 1);
        chk("preempt_armed_disp", disp_page, 3);
        exp_req_q.push_back(10);
        exp_com_q.push_back(10);
        isboss = 1'b1;
        repeat (20) tick();
        chk("preempt_no_commit_2", disp_page, 3);
        chk("preempt_boss_req_seen", exp_req_q.size(), 0);
        frame(1);
        chk("preempt_disp_page", disp_page, 10);
        chk("preempt_disp_base", disp_base, 3072000);

        // Ack withheld 50 cycles: load_req high for 51.
        ack_dly = 50;
        isboss  = 1'b0;
        picnum  = 5'd5;
        exp_req_q.push_back(5);
        frame(3);
        w = 0;
        while (load_req && w < 200) begin
            tick();
            w++;
        end
        chk("hold_req_released", load_req, 0);
        repeat (10) tick();
        chk("hold_req_len", last_len, 51);
        ack_dly = 2;
        exp_com_q.push_back(5);
        frame(1);
        chk("hold_disp_page", disp_page, 5);

        // load_done never arrives: err 100 cycles after WAIT_DONE entry, then retry.
        done_en = 1'b0;
        err_ok  = 1'b1;
        exp_req_q.push_back(10);
        exp_req_q.push_back(10);
        isboss = 1'b1;
        w = 0;
        while (!load_req && w < 50) begin
            tick();
            w++;
        end
        chk("tmo_req_raised", load_req, 1);
        w = 0;
        while (load_req && w < 50) begin
            tick();
            w++;
        end
        chk("tmo_req_acked", load_req, 0);
        n = 0;
        while (!err && n < 300) begin
            tick();
            n++;
        end
        chk("tmo_err_cycles", n, 100);
        chk("tmo_err_load_req", load_req, 0);
        chk("tmo_err_busy", busy, 0);
        tick();
        chk("tmo_err_pulse", err, 0);
        chk("tmo_disp_kept", disp_page, 5);
        chk("tmo_retry_req", load_req, 1);
        repeat (3) tick();

        // Asynchronous reset in mid-handshake clears outputs at once.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_load_req", load_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_disp_page", disp_page, 0);
        chk("arst_disp_base", disp_base, 0);
        chk("arst_req_pending", exp_req_q.size(), 0);
        err_ok  = 1'b0;
        done_en = 1'b1;
        isboss  = 1'b0;
        picnum  = 5'd15;
        repeat (3) tick();
        rst_n = 1'b1;
        frame(5);
        chk("inv_disp_page", disp_page, 0);
        chk("inv_busy", busy, 0);
        chk("end_req_pending", exp_req_q.size(), 0);
        chk("end_commit_pending", exp_com_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
